id_ex_stage: RTL and testbench

//  Decode-to-execute pipeline register downstream of the register file. Latches the

---
 rtl/id_ex_stage_pkg.sv | 33 +++
 rtl/id_ex_stage_if.sv | 62 ++++++
 rtl/id_ex_stage_operand_bypass.sv | 34 +++
 rtl/id_ex_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_stage.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Package : riscv_pipe_pkg
//  Control bundle bit layout shared by the decode and execute stages.
//  Revision: 1.0
// ============================================================================
package riscv_pipe_pkg;

    localparam int CTRL_BITS      = 8;
    localparam int CTRL_MEM_READ  = 0;
    localparam int CTRL_REG_WRITE = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_ALU_SRC   = 3;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_ALU_OP_LO = 5;
    localparam int CTRL_ALU_OP_HI = 7;

    // ALU_OP code for "pass immediate" (lui-style): rs1 is not read.
    localparam logic [2:0] ALU_OP_PASS_IMM = 3'b111;

    localparam logic [CTRL_BITS-1:0] BUBBLE_CTRL = '0;

    function automatic logic uses_rs1(input logic [CTRL_BITS-1:0] ctrl);
        return ctrl[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] != ALU_OP_PASS_IMM;
    endfunction

    // rs2 is read by register-register ALU ops, stores and branches.
    function automatic logic uses_rs2(input logic [CTRL_BITS-1:0] ctrl);
        return ~ctrl[CTRL_ALU_SRC] | ctrl[CTRL_MEM_WRITE] | ctrl[CTRL_BRANCH];
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Interface : id_ex_stage_if
//  ID-side inputs, forwarding sources, hazard control and EX-side outputs.
//  Revision  : 1.0
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 8,
    parameter int CNT_W      = 16
);
    logic                  valid_in;
    logic [XLEN-1:0]       pc_in;
    logic [REG_ADDR_W-1:0] rs1_addr_in;
    logic [REG_ADDR_W-1:0] rs2_addr_in;
    logic [REG_ADDR_W-1:0] rd_addr_in;
    logic [XLEN-1:0]       rs1_data_in;
    logic [XLEN-1:0]       rs2_data_in;
    logic [XLEN-1:0]       imm_in;
    logic [CTRL_W-1:0]     ctrl_in;
    logic [REG_ADDR_W-1:0] ex_mem_rd;
    logic                  ex_mem_reg_write;
    logic                  ex_mem_mem_read;
    logic [XLEN-1:0]       ex_mem_result;
    logic [REG_ADDR_W-1:0] mem_wb_rd;
    logic                  mem_wb_reg_write;
    logic [XLEN-1:0]       mem_wb_data;
    logic                  flush;
    logic                  hold_in;

    logic                  stall_out;
    logic                  valid_out;
    logic [XLEN-1:0]       pc_out;
    logic [XLEN-1:0]       imm_out;
    logic [REG_ADDR_W-1:0] rd_out;
    logic [REG_ADDR_W-1:0] rs1_addr_out;
    logic [REG_ADDR_W-1:0] rs2_addr_out;
    logic [XLEN-1:0]       operand_1_out;
    logic [XLEN-1:0]       operand_2_out;
    logic [CTRL_W-1:0]     ctrl_out;
    logic [CNT_W-1:0]      bubble_count;

    modport master (
        output valid_in, pc_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
               rs1_data_in, rs2_data_in, imm_in, ctrl_in,
               ex_mem_rd, ex_mem_reg_write, ex_mem_mem_read, ex_mem_result,
               mem_wb_rd, mem_wb_reg_write, mem_wb_data, flush, hold_in,
        input  stall_out, valid_out, pc_out, imm_out, rd_out, rs1_addr_out,
               rs2_addr_out, operand_1_out, operand_2_out, ctrl_out, bubble_count
    );

    modport slave (
        input  valid_in, pc_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
               rs1_data_in, rs2_data_in, imm_in, ctrl_in,
               ex_mem_rd, ex_mem_reg_write, ex_mem_mem_read, ex_mem_result,
               mem_wb_rd, mem_wb_reg_write, mem_wb_data, flush, hold_in,
        output stall_out, valid_out, pc_out, imm_out, rd_out, rs1_addr_out,
               rs2_addr_out, operand_1_out, operand_2_out, ctrl_out, bubble_count
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_operand_bypass.sv
`default_nettype none
// ============================================================================
//  Module  : operand_bypass
//  Three-way source operand mux: EX/MEM result, MEM/WB data, regfile data.
//  Revision: 1.0
// ============================================================================
module operand_bypass #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  wire logic [REG_ADDR_W-1:0] rs,
    input  wire logic [XLEN-1:0]       rf_data,
    input  wire logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  wire logic                  ex_mem_reg_write,
    input  wire logic                  ex_mem_mem_read,
    input  wire logic [XLEN-1:0]       ex_mem_result,
    input  wire logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  wire logic                  mem_wb_reg_write,
    input  wire logic [XLEN-1:0]       mem_wb_data,
    output logic      [XLEN-1:0]       operand
);
    // A load in EX/MEM has no data yet; the hazard logic stalls instead.
    always_comb begin
        operand = rf_data;
        if (rs == '0) begin
            operand = '0;
        end else if (ex_mem_reg_write && !ex_mem_mem_read && (ex_mem_rd == rs)) begin
            operand = ex_mem_result;
        end else if (mem_wb_reg_write && (mem_wb_rd == rs)) begin
            operand = mem_wb_data;
        end
    end
endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module  : id_ex_stage
//  ID/EX pipeline register with capture-time bypass and load-use stall.
//  Revision: 1.0
// ============================================================================
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 8,
    parameter int CNT_W      = 16
) (
    input  wire logic   clock,
    input  wire logic   reset,
    id_ex_stage_if.slave bus
);
    logic                  ex_valid;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_imm;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [XLEN-1:0]       ex_op1;
    logic [XLEN-1:0]       ex_op2;
    logic [CTRL_W-1:0]     ex_ctrl;
    logic [CNT_W-1:0]      bubbles;

    logic [XLEN-1:0]       fwd_op1;
    logic [XLEN-1:0]       fwd_op2;
    logic [CTRL_BITS-1:0]  id_ctrl;
    logic                  use_rs1;
    logic                  use_rs2;
    logic                  ex_load_hit;
    logic                  mem_load_hit;
    logic                  haz;

    assign id_ctrl = bus.ctrl_in[CTRL_BITS-1:0];
    assign use_rs1 = uses_rs1(id_ctrl);
    assign use_rs2 = uses_rs2(id_ctrl);

    // Load sitting in this stage's output register, i.e. currently in EX.
    assign ex_load_hit = ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_rd != '0) &&
                         ((use_rs1 && (ex_rd == bus.rs1_addr_in)) ||
                          (use_rs2 && (ex_rd == bus.rs2_addr_in)));

    assign mem_load_hit = bus.ex_mem_mem_read && (bus.ex_mem_rd != '0) &&
                          ((use_rs1 && (bus.ex_mem_rd == bus.rs1_addr_in)) ||
                           (use_rs2 && (bus.ex_mem_rd == bus.rs2_addr_in)));

    assign haz           = bus.valid_in && !bus.flush && (ex_load_hit || mem_load_hit);
    assign bus.stall_out = haz || bus.hold_in;

    operand_bypass #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_bypass_rs1 (
        .rs               (bus.rs1_addr_in),
        .rf_data          (bus.rs1_data_in),
        .ex_mem_rd        (bus.ex_mem_rd),
        .ex_mem_reg_write (bus.ex_mem_reg_write),
        .ex_mem_mem_read  (bus.ex_mem_mem_read),
        .ex_mem_result    (bus.ex_mem_result),
        .mem_wb_rd        (bus.mem_wb_rd),
        .mem_wb_reg_write (bus.mem_wb_reg_write),
        .mem_wb_data      (bus.mem_wb_data),
        .operand          (fwd_op1)
    );

    operand_bypass #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_bypass_rs2 (
        .rs               (bus.rs2_addr_in),
        .rf_data          (bus.rs2_data_in),
        .ex_mem_rd        (bus.ex_mem_rd),
        .ex_mem_reg_write (bus.ex_mem_reg_write),
        .ex_mem_mem_read  (bus.ex_mem_mem_read),
        .ex_mem_result    (bus.ex_mem_result),
        .mem_wb_rd        (bus.mem_wb_rd),
        .mem_wb_reg_write (bus.mem_wb_reg_write),
        .mem_wb_data      (bus.mem_wb_data),
        .operand          (fwd_op2)
    );

    // Bubbles clear only valid/ctrl; the remaining fields keep their old values.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_imm   <= '0;
            ex_rd    <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_ctrl  <= '0;
            bubbles  <= '0;
        end else if (bus.hold_in) begin
            ex_valid <= ex_valid;
        end else if (bus.flush || haz) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            if (haz && (bubbles != {CNT_W{1'b1}})) begin
                bubbles <= bubbles + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ex_valid <= bus.valid_in;
            ex_pc    <= bus.pc_in;
            ex_imm   <= bus.imm_in;
            ex_rd    <= bus.rd_addr_in;
            ex_rs1   <= bus.rs1_addr_in;
            ex_rs2   <= bus.rs2_addr_in;
            ex_op1   <= fwd_op1;
            ex_op2   <= fwd_op2;
            ex_ctrl  <= bus.valid_in ? bus.ctrl_in : '0;
        end
    end

    assign bus.valid_out     = ex_valid;
    assign bus.pc_out        = ex_pc;
    assign bus.imm_out       = ex_imm;
    assign bus.rd_out        = ex_rd;
    assign bus.rs1_addr_out  = ex_rs1;
    assign bus.rs2_addr_out  = ex_rs2;
    assign bus.operand_1_out = ex_op1;
    assign bus.operand_2_out = ex_op2;
    assign bus.ctrl_out      = ex_ctrl;
    assign bus.bubble_count  = bubbles;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_id_ex_stage
//  Directed self-checking bench for id_ex_stage.
//  Revision: 1.0
// ============================================================================
module tb_id_ex_stage;
    localparam int CW = 8;
    localparam logic [7:0] LW_CTRL  = 8'h0B;
    localparam logic [7:0] ADD_CTRL = 8'h02;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    id_ex_stage_if #(.XLEN(32), .REG_ADDR_W(5), .CTRL_W(8), .CNT_W(CW)) bus ();

    id_ex_stage #(.XLEN(32), .REG_ADDR_W(5), .CTRL_W(8), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.valid_in = 0; bus.pc_in = 0; bus.rs1_addr_in = 0; bus.rs2_addr_in = 0;
        bus.rd_addr_in = 0; bus.rs1_data_in = 0; bus.rs2_data_in = 0; bus.imm_in = 0;
        bus.ctrl_in = 0; bus.ex_mem_rd = 0; bus.ex_mem_reg_write = 0;
        bus.ex_mem_mem_read = 0; bus.ex_mem_result = 0; bus.mem_wb_rd = 0;
        bus.mem_wb_reg_write = 0; bus.mem_wb_data = 0; bus.flush = 0; bus.hold_in = 0;
    endtask

    task automatic id_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [7:0] ctrl);
        bus.valid_in = 1; bus.pc_in = pc; bus.rs1_addr_in = rs1; bus.rs2_addr_in = rs2;
        bus.rd_addr_in = rd; bus.rs1_data_in = d1; bus.rs2_data_in = d2;
        bus.imm_in = imm; bus.ctrl_in = ctrl;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        tick(); tick();
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.valid_out); end
        checks++; if (bus.ctrl_out !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h want 00", bus.ctrl_out); end
        checks++; if (bus.bubble_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.bubble_count); end
        reset = 0;
        // load into EX, then dependent add in ID, then reset (with hold) mid-stream
        id_instr(32'h100, 5'd2, 5'd0, 5'd6, 32'h1000, 32'h0, 32'h4, LW_CTRL);
        tick();
        checks++; if (bus.valid_out !== 1'b1 || bus.rd_out !== 5'd6) begin errors++; $display("FAIL reset_preload got v=%0b rd=%0d want v=1 rd=6", bus.valid_out, bus.rd_out); end
        id_instr(32'h104, 5'd6, 5'd1, 5'd7, 32'h0, 32'h0, 32'h0, ADD_CTRL);
        #1;
        checks++; if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL reset_prestall got %0b want 1", bus.stall_out); end
        reset = 1; bus.hold_in = 1;
        tick();
        checks++; if (bus.valid_out !== 1'b0 || bus.ctrl_out !== 8'h00 || bus.pc_out !== 32'h0 ||
                      bus.rd_out !== 5'd0 || bus.operand_1_out !== 32'h0 || bus.imm_out !== 32'h0)
            begin errors++; $display("FAIL reset_mid got v=%0b ctrl=%h pc=%h rd=%0d want all 0", bus.valid_out, bus.ctrl_out, bus.pc_out, bus.rd_out); end
        bus.hold_in = 0;
        #1;
        checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", bus.stall_out); end
        reset = 0; idle();
        tick();
    endtask

    task automatic test_bypass();
        id_instr(32'h300, 5'd5, 5'd3, 5'd9, 32'h1111, 32'h3333, 32'hFFFF_FFF0, ADD_CTRL);
        bus.ex_mem_rd = 5; bus.ex_mem_reg_write = 1; bus.ex_mem_result = 32'hAAAA;
        bus.mem_wb_rd = 5; bus.mem_wb_reg_write = 1; bus.mem_wb_data = 32'hBBBB;
        tick();
        checks++; if (bus.operand_1_out !== 32'hAAAA) begin errors++; $display("FAIL bypass_exmem got %h want 0000aaaa", bus.operand_1_out); end
        checks++; if (bus.operand_2_out !== 32'h3333) begin errors++; $display("FAIL bypass_rf2 got %h want 00003333", bus.operand_2_out); end
        checks++; if (bus.pc_out !== 32'h300 || bus.imm_out !== 32'hFFFF_FFF0 || bus.rd_out !== 5'd9 ||
                      bus.rs1_addr_out !== 5'd5 || bus.rs2_addr_out !== 5'd3 || bus.ctrl_out !== ADD_CTRL || bus.valid_out !== 1'b1)
            begin errors++; $display("FAIL latch_fields got pc=%h imm=%h rd=%0d ctrl=%h want pc=300 imm=fffffff0 rd=9 ctrl=02", bus.pc_out, bus.imm_out, bus.rd_out, bus.ctrl_out); end
        bus.ex_mem_rd = 9;
        tick();
        checks++; if (bus.operand_1_out !== 32'hBBBB) begin errors++; $display("FAIL bypass_memwb got %h want 0000bbbb", bus.operand_1_out); end
        bus.mem_wb_reg_write = 0;
        bus.ex_mem_rd = 3; bus.ex_mem_result = 32'h7777;
        tick();
        checks++; if (bus.operand_1_out !== 32'h1111 || bus.operand_2_out !== 32'h7777) begin errors++; $display("FAIL bypass_mix got op1=%h op2=%h want 00001111 00007777", bus.operand_1_out, bus.operand_2_out); end
        idle();
        tick();
    endtask

    task automatic test_zero_reg();
        id_instr(32'h400, 5'd4, 5'd0, 5'd10, 32'h44, 32'h1234, 32'h0, ADD_CTRL);
        bus.ex_mem_rd = 0; bus.ex_mem_reg_write = 1; bus.ex_mem_result = 32'hFFFF;
        bus.mem_wb_rd = 0; bus.mem_wb_reg_write = 1; bus.mem_wb_data = 32'hFFFF;
        tick();
        checks++; if (bus.operand_2_out !== 32'h0 || bus.operand_1_out !== 32'h44) begin errors++; $display("FAIL zero_reg got op2=%h op1=%h want 0 00000044", bus.operand_2_out, bus.operand_1_out); end
        idle();
        tick();
    endtask

    task automatic test_load_use();
        id_instr(32'h500, 5'd2, 5'd0, 5'd6, 32'h2000, 32'h0, 32'h4, LW_CTRL);
        tick();
        id_instr(32'h504, 5'd6, 5'd1, 5'd7, 32'hDEAD, 32'h10, 32'h0, ADD_CTRL);
        #1;
        checks++; if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall1 got %0b want 1", bus.stall_out); end
        tick();
        checks++; if (bus.valid_out !== 1'b0 || bus.ctrl_out !== 8'h00 || bus.bubble_count !== 8'd1) begin errors++; $display("FAIL lu_bubble1 got v=%0b ctrl=%h cnt=%0d want 0 00 1", bus.valid_out, bus.ctrl_out, bus.bubble_count); end
        bus.ex_mem_rd = 6; bus.ex_mem_mem_read = 1; bus.ex_mem_reg_write = 1; bus.ex_mem_result = 32'h2004;
        #1;
        checks++; if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall2 got %0b want 1", bus.stall_out); end
        tick();
        checks++; if (bus.valid_out !== 1'b0 || bus.bubble_count !== 8'd2) begin errors++; $display("FAIL lu_bubble2 got v=%0b cnt=%0d want 0 2", bus.valid_out, bus.bubble_count); end
        bus.ex_mem_rd = 0; bus.ex_mem_mem_read = 0; bus.ex_mem_reg_write = 0; bus.ex_mem_result = 0;
        bus.mem_wb_rd = 6; bus.mem_wb_reg_write = 1; bus.mem_wb_data = 32'hCAFE_F00D;
        #1;
        checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL lu_release got %0b want 0", bus.stall_out); end
        tick();
        checks++; if (bus.valid_out !== 1'b1 || bus.rd_out !== 5'd7 || bus.operand_1_out !== 32'hCAFE_F00D ||
                      bus.operand_2_out !== 32'h10 || bus.bubble_count !== 8'd2)
            begin errors++; $display("FAIL lu_capture got v=%0b rd=%0d op1=%h op2=%h cnt=%0d want 1 7 cafef00d 00000010 2", bus.valid_out, bus.rd_out, bus.operand_1_out, bus.operand_2_out, bus.bubble_count); end
        idle();
        tick();
    endtask

    task automatic test_flush_haz();
        id_instr(32'h600, 5'd2, 5'd0, 5'd6, 32'h3000, 32'h0, 32'h8, LW_CTRL);
        tick();
        id_instr(32'h604, 5'd6, 5'd1, 5'd7, 32'h0, 32'h0, 32'h0, ADD_CTRL);
        bus.flush = 1;
        #1;
        checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", bus.stall_out); end
        tick();
        checks++; if (bus.valid_out !== 1'b0 || bus.ctrl_out !== 8'h00 || bus.bubble_count !== 8'd2) begin errors++; $display("FAIL flush_bubble got v=%0b ctrl=%h cnt=%0d want 0 00 2", bus.valid_out, bus.ctrl_out, bus.bubble_count); end
        idle();
        tick();
    endtask

    task automatic test_hold();
        id_instr(32'h200, 5'd3, 5'd4, 5'd8, 32'h33, 32'h44, 32'h7, ADD_CTRL);
        tick();
        checks++; if (bus.valid_out !== 1'b1 || bus.pc_out !== 32'h200 || bus.operand_1_out !== 32'h33) begin errors++; $display("FAIL hold_pre got v=%0b pc=%h op1=%h want 1 200 33", bus.valid_out, bus.pc_out, bus.operand_1_out); end
        id_instr(32'h204, 5'd8, 5'd4, 5'd9, 32'h99, 32'h98, 32'h1, ADD_CTRL);
        bus.ex_mem_rd = 8; bus.ex_mem_mem_read = 1; bus.ex_mem_reg_write = 1;
        bus.hold_in = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.flush = 1;
            tick();
            checks++; if (bus.valid_out !== 1'b1 || bus.pc_out !== 32'h200 || bus.operand_1_out !== 32'h33 ||
                          bus.operand_2_out !== 32'h44 || bus.rd_out !== 5'd8 || bus.ctrl_out !== ADD_CTRL ||
                          bus.bubble_count !== 8'd2 || bus.stall_out !== 1'b1)
                begin errors++; $display("FAIL hold_frozen cycle %0d got v=%0b pc=%h op1=%h cnt=%0d stall=%0b want 1 200 33 2 1", i, bus.valid_out, bus.pc_out, bus.operand_1_out, bus.bubble_count, bus.stall_out); end
        end
        bus.hold_in = 0;
        #1;
        checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL hold_release_stall got %0b want 0", bus.stall_out); end
        tick();
        checks++; if (bus.valid_out !== 1'b0 || bus.ctrl_out !== 8'h00 || bus.bubble_count !== 8'd2) begin errors++; $display("FAIL hold_flush got v=%0b ctrl=%h cnt=%0d want 0 00 2", bus.valid_out, bus.ctrl_out, bus.bubble_count); end
        idle();
        tick();
    endtask

    task automatic test_saturation();
        id_instr(32'h700, 5'd6, 5'd1, 5'd7, 32'h0, 32'h0, 32'h0, ADD_CTRL);
        bus.ex_mem_rd = 6; bus.ex_mem_mem_read = 1; bus.ex_mem_reg_write = 1;
        tick();
        checks++; if (bus.bubble_count !== 8'd3) begin errors++; $display("FAIL sat_first got %0d want 3", bus.bubble_count); end
        for (int i = 0; i < 252; i++) tick();
        checks++; if (bus.bubble_count !== 8'hFF) begin errors++; $display("FAIL sat_reach got %0d want 255", bus.bubble_count); end
        tick(); tick(); tick();
        checks++; if (bus.bubble_count !== 8'hFF || bus.stall_out !== 1'b1 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL sat_hold got cnt=%0d stall=%0b v=%0b want 255 1 0", bus.bubble_count, bus.stall_out, bus.valid_out); end
        idle();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1;
        idle();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_load_use();
        test_flush_haz();
        test_hold();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
